game_round_ctrl: RTL and testbench
==================================

Name: game_round_ctrl

Overview:
Round sequencer for the button guessing game. Sits between the difficulty tick generators and the guess FSM. It gates the FSM speed enable, restarts the FSM between rounds, and tracks score and lives. It also supports pause, and drives a display code that the top level decodes onto the 7-segment display.

Parameters:
LIVES, 3, lives at game start (1..7)
SCORE_W, 8, score register width; score saturates at 2^SCORE_W-1
HOLD_TICKS, 4, selected-speed enable ticks for which a round result is held before the next round (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_tick  in  1  debounced one-cycle pulse: start game / pause / resume
diff_sel  in  1  difficulty switch: 0 easy, 1 hard
tick_easy  in  1  one-cycle enable pulse, slow rate
tick_hard  in  1  one-cycle enable pulse, fast rate
win  in  1  level from guess FSM; high while it reports a win
lose  in  1  level from guess FSM; high while it reports a loss
fsm_en  out  1  registered enable to the guess FSM
fsm_clr  out  1  synchronous clear to the guess FSM, active high
score  out  SCORE_W  rounds won this game
lives  out  3  remaining lives
disp_code  out  3  0 blank, 1 win, 2 lose, 3 paused, 4 game over
game_over  out  1  high in OVER state

Behaviour:
- Reset (async, rst_n=0) values:
  - state IDLE, fsm_en 0, fsm_clr 1.
  - score 0, lives LIVES, disp_code 0, game_over 0.
  - diff_q 0, hold counter 0.
- Selected tick sel_tick = diff_q ? tick_hard : tick_easy, where diff_q is the latched difficulty.
- All outputs are registered. fsm_en equals sel_tick delayed one cycle while in PLAY, and is 0 otherwise.
- IDLE:
  - fsm_clr=1, disp_code 0.
  - On start_tick: latch diff_q<=diff_sel, score<=0, lives<=LIVES, go to CLEAR.
- CLEAR: one cycle only. fsm_clr=1, hold counter<=0, diff_q<=diff_sel, then go to PLAY. Difficulty changes take effect only here.
- PLAY:
  - fsm_clr=0, disp_code 0.
  - Priority order in a single cycle: win > lose > start_tick.
  - win=1: score<=score+1, saturating; result<=WIN; go to HOLD.
  - lose=1: lives<=lives-1; result<=LOSE; go to HOLD.
  - start_tick: go to PAUSE.
- PAUSE:
  - fsm_en=0, fsm_clr=0, so FSM state is preserved. disp_code 3.
  - start_tick: return to PLAY. Ticks that arrive during PAUSE are dropped.
- HOLD:
  - fsm_en=0, fsm_clr=0, so the FSM keeps its result. disp_code is 1 (WIN) or 2 (LOSE).
  - Each sel_tick increments the hold counter.
  - On the tick that makes the count equal HOLD_TICKS:
    - if result==LOSE and lives==0, go to OVER;
    - otherwise go to CLEAR.
  - start_tick in HOLD is ignored.
- OVER:
  - game_over=1, fsm_clr=1, disp_code 4. Score and lives are frozen for display.
  - start_tick: same action as from IDLE (new game via CLEAR).
- lives never underflows, because the lose decrement is only reachable with lives>=1.
- win/lose are sampled only in PLAY. Levels that remain high in HOLD have no further effect.
- Reset asserted mid-round returns every output to its reset value immediately. No round result survives.
- Latency:
  - start_tick to first fsm_clr deassertion: 2 cycles (IDLE→CLEAR→PLAY).
  - win/lose to score/lives update: 1 cycle.

Decomposition:
- Shared package game_pkg holds:
  - the state enum {IDLE, CLEAR, PLAY, PAUSE, HOLD, OVER};
  - the result enum {WIN, LOSE};
  - the disp_code constants DISP_BLANK/WIN/LOSE/PAUSE/OVER.
- One sub-module, hold_timer: a tick-counted down-timer with load and done outputs, used in HOLD.
- Score/lives arithmetic stays inline.

Test Plan:
1. Reset, then start_tick with diff_sel=0 → CLEAR for 1 cycle; fsm_clr falls 2 cycles after the pulse; fsm_en pulses 1 cycle after each tick_easy; tick_hard is ignored.
2. Win level in PLAY with HOLD_TICKS=4 → score 0→1 after 1 cycle; disp_code=1; fsm_en=0; after the 4th tick, fsm_clr pulses 1 cycle and the game returns to PLAY.
3. Three losses with LIVES=3 → lives 3→2→1→0; after the third HOLD, go to OVER with game_over=1, disp_code=4, fsm_clr=1; then start_tick → score 0, lives 3, PLAY.
4. win and lose high together with start_tick in the same cycle → score increments, lives unchanged, HOLD with result WIN (no pause).
5. start_tick in PLAY → PAUSE with disp_code 3; 5 ticks are delivered and fsm_en stays 0; start_tick → PLAY, and fsm_en resumes on the next tick. Also set diff_sel=1 mid-round → no effect until CLEAR.
6. Score at 255 (SCORE_W=8) plus a win → stays 255. rst_n low mid-HOLD → all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and display codes for the button guessing game.
// Imported by the round controller and its hold timer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    PLAY,
    PAUSE,
    HOLD,
    OVER
  } state_t;

  typedef enum logic {
    WIN,
    LOSE
  } result_t;

  localparam logic [2:0] DISP_BLANK = 3'd0;
  localparam logic [2:0] DISP_WIN   = 3'd1;
  localparam logic [2:0] DISP_LOSE  = 3'd2;
  localparam logic [2:0] DISP_PAUSE = 3'd3;
  localparam logic [2:0] DISP_OVER  = 3'd4;

  function automatic logic [2:0] disp_of(
    input state_t  s,
    input result_t r
  );
    logic [2:0] d;
    d = DISP_BLANK;
    case (s)
      PAUSE:   d = DISP_PAUSE;
      HOLD:    d = (r == LOSE) ? DISP_LOSE : DISP_WIN;
      OVER:    d = DISP_OVER;
      default: d = DISP_BLANK;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/game_round_ctrl_hold_timer.sv
// Tick-counted down-timer that paces the result hold between rounds.
// done pulses on the tick that exhausts the loaded count.
module hold_timer #(
  parameter int HOLD_TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(HOLD_TICKS);
    end else if (tick && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign done = tick && (cnt == 4'd1);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: gates the guess FSM, restarts it between rounds,
// and tracks score, lives, pause and the display code.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int LIVES      = 3,
  parameter int SCORE_W    = 8,
  parameter int HOLD_TICKS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_tick,
  input  logic               diff_sel,
  input  logic               tick_easy,
  input  logic               tick_hard,
  input  logic               win,
  input  logic               lose,
  output logic               fsm_en,
  output logic               fsm_clr,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [2:0]         disp_code,
  output logic               game_over
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  state_t  state, nxt;
  result_t result, res_nxt;
  logic    diff_q;
  logic    sel_tick;
  logic    hold_load;
  logic    hold_done;

  assign sel_tick = diff_q ? tick_hard : tick_easy;
  assign hold_load = (state == PLAY) && (win || lose);

  hold_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_hold (
    .clk  (clk),
    .rst_n(rst_n),
    .load (hold_load),
    .tick ((state == HOLD) && sel_tick),
    .done (hold_done)
  );

  always_comb begin
    nxt = state;
    res_nxt = result;
    case (state)
      IDLE, OVER: begin
        if (start_tick) nxt = CLEAR;
      end
      CLEAR: nxt = PLAY;
      PLAY: begin
        if (win) begin
          nxt = HOLD;
          res_nxt = WIN;
        end else if (lose) begin
          nxt = HOLD;
          res_nxt = LOSE;
        end else if (start_tick) begin
          nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (start_tick) nxt = PLAY;
      end
      HOLD: begin
        if (hold_done) begin
          nxt = (result == LOSE && lives == 3'd0)
              ? OVER : CLEAR;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      result    <= WIN;
      diff_q    <= 1'b0;
      score     <= '0;
      lives     <= LIVES_INIT;
      fsm_en    <= 1'b0;
      fsm_clr   <= 1'b1;
      disp_code <= DISP_BLANK;
      game_over <= 1'b0;
    end else begin
      state     <= nxt;
      result    <= res_nxt;
      fsm_en    <= sel_tick && (nxt == PLAY)
                && (state != PAUSE);
      fsm_clr   <= (nxt == IDLE) || (nxt == CLEAR)
                || (nxt == OVER);
      disp_code <= disp_of(nxt, res_nxt);
      game_over <= (nxt == OVER);
      case (state)
        IDLE, OVER: begin
          if (start_tick) begin
            diff_q <= diff_sel;
            score  <= '0;
            lives  <= LIVES_INIT;
          end
        end
        CLEAR: diff_q <= diff_sel;
        PLAY: begin
          if (win) begin
            if (score != SCORE_MAX) score <= score + 1'b1;
          end else if (lose) begin
            lives <= lives - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: flag-based round model
// compared every cycle, plus literal checkpoints.
module tb_game_round_ctrl;

  localparam int LIVES = 3;
  localparam int SW    = 8;
  localparam int HT    = 4;
  localparam int SMAX  = 255;

  logic clk = 0;
  logic rst_n = 0;
  logic start_tick = 0;
  logic diff_sel = 0;
  logic tick_easy = 0;
  logic tick_hard = 0;
  logic win = 0;
  logic lose = 0;
  logic fsm_en, fsm_clr, game_over;
  logic [SW-1:0] score;
  logic [2:0] lives, disp_code;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  game_round_ctrl #(
    .LIVES(LIVES), .SCORE_W(SW), .HOLD_TICKS(HT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .start_tick(start_tick), .diff_sel(diff_sel),
    .tick_easy(tick_easy), .tick_hard(tick_hard),
    .win(win), .lose(lose),
    .fsm_en(fsm_en), .fsm_clr(fsm_clr),
    .score(score), .lives(lives),
    .disp_code(disp_code), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Tick sources: easy every 6 cycles, hard every 2.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tick_easy = (cyc % 6 == 0);
      tick_hard = (cyc % 2 == 1);
    end
  end

  // Round model as mode flags.
  bit m_idle, m_clear, m_paused, m_hold, m_over;
  bit m_lose_res, m_hard, m_en;
  int m_score, m_lives, m_left;
  wire m_sel = m_hard ? tick_hard : tick_easy;

  function automatic bit playing();
    return !(m_idle || m_clear || m_paused
             || m_hold || m_over);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1; m_clear <= 0; m_paused <= 0;
      m_hold <= 0; m_over <= 0; m_lose_res <= 0;
      m_hard <= 0; m_en <= 0; m_left <= 0;
      m_score <= 0; m_lives <= LIVES;
    end else begin
      m_en <= 0;
      if (m_idle || m_over) begin
        if (start_tick) begin
          m_idle <= 0; m_over <= 0; m_clear <= 1;
          m_hard <= diff_sel;
          m_score <= 0; m_lives <= LIVES;
        end
      end else if (m_clear) begin
        m_clear <= 0;
        m_hard <= diff_sel;
        m_en <= m_sel;
      end else if (m_paused) begin
        if (start_tick) m_paused <= 0;
      end else if (m_hold) begin
        if (m_sel) begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hold <= 0;
            if (m_lose_res && m_lives == 0) m_over <= 1;
            else m_clear <= 1;
          end
        end
      end else begin
        if (win) begin
          m_score <= (m_score >= SMAX) ? SMAX : m_score + 1;
          m_hold <= 1; m_lose_res <= 0; m_left <= HT;
        end else if (lose) begin
          m_lives <= m_lives - 1;
          m_hold <= 1; m_lose_res <= 1; m_left <= HT;
        end else if (start_tick) begin
          m_paused <= 1;
        end else begin
          m_en <= m_sel;
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int ed;
    ed = m_over ? 4 : m_paused ? 3
       : m_hold ? (m_lose_res ? 2 : 1) : 0;
    chk("fsm_en", int'(fsm_en), int'(m_en));
    chk("fsm_clr", int'(fsm_clr),
        int'(m_idle || m_clear || m_over));
    chk("score", int'(score), m_score);
    chk("lives", int'(lives), m_lives);
    chk("disp_code", int'(disp_code), ed);
    chk("game_over", int'(game_over), int'(m_over));
  end

  task automatic cyc_n(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_tick = 1;
    cyc_n(1);
    start_tick = 0;
  endtask

  task automatic wait_play();
    int k = 0;
    while (!playing() && k < 200) begin
      cyc_n(1);
      k++;
    end
    if (!playing()) chk("wait_play_timeout", 0, 1);
  endtask

  task automatic wait_unhold();
    int k = 0;
    while (m_hold && k < 200) begin
      cyc_n(1);
      k++;
    end
    if (m_hold) chk("wait_hold_timeout", 0, 1);
  endtask

  task automatic count_en(int n, output int c);
    c = 0;
    repeat (n) begin
      cyc_n(1);
      c += int'(fsm_en);
    end
  endtask

  initial begin
    int c, k;
    cyc_n(3);
    chk("rst_fsm_clr", int'(fsm_clr), 1);
    chk("rst_fsm_en", int'(fsm_en), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_lives", int'(lives), 3);
    chk("rst_disp", int'(disp_code), 0);
    rst_n = 1;
    cyc_n(2);

    // start, easy speed
    pulse_start();
    chk("clear_clr", int'(fsm_clr), 1);
    cyc_n(1);
    chk("play_clr", int'(fsm_clr), 0);
    count_en(24, c);
    chk("easy_en_count", c, 4);

    // win held two cycles
    win = 1;
    cyc_n(1);
    chk("win_score", int'(score), 1);
    chk("win_disp", int'(disp_code), 1);
    chk("win_en", int'(fsm_en), 0);
    cyc_n(1);
    win = 0;
    k = 0;
    while (!fsm_clr && k < 100) begin
      cyc_n(1);
      k++;
    end
    chk("hold_clr_pulse", int'(fsm_clr), 1);
    cyc_n(1);
    chk("after_clear_clr", int'(fsm_clr), 0);
    chk("after_clear_score", int'(score), 1);

    // three losses to game over
    for (int i = 0; i < 3; i++) begin
      wait_play();
      lose = 1;
      cyc_n(1);
      lose = 0;
      chk("lose_lives", int'(lives), 2 - i);
      chk("lose_disp", int'(disp_code), 2);
      wait_unhold();
    end
    chk("over_flag", int'(game_over), 1);
    chk("over_disp", int'(disp_code), 4);
    chk("over_clr", int'(fsm_clr), 1);
    chk("over_score", int'(score), 1);
    cyc_n(3);
    pulse_start();
    cyc_n(1);
    chk("new_score", int'(score), 0);
    chk("new_lives", int'(lives), 3);
    chk("new_clr", int'(fsm_clr), 0);

    // win+lose+start together
    win = 1; lose = 1; start_tick = 1;
    cyc_n(1);
    win = 0; lose = 0; start_tick = 0;
    chk("prio_score", int'(score), 1);
    chk("prio_lives", int'(lives), 3);
    chk("prio_disp", int'(disp_code), 1);
    wait_play();

    // pause, difficulty change mid-round
    pulse_start();
    chk("pause_disp", int'(disp_code), 3);
    diff_sel = 1;
    count_en(35, c);
    chk("pause_en_count", c, 0);
    pulse_start();
    chk("resume_disp", int'(disp_code), 0);
    count_en(24, c);
    chk("still_easy_count", c, 4);
    win = 1;
    cyc_n(1);
    win = 0;
    wait_play();
    count_en(24, c);
    chk("hard_en_count", c, 12);

    // saturate score
    for (int i = 0; i < 260; i++) begin
      wait_play();
      win = 1;
      cyc_n(1);
      win = 0;
      wait_unhold();
    end
    chk("sat_score", int'(score), 255);
    wait_play();
    win = 1;
    cyc_n(1);
    win = 0;
    chk("sat_hold_score", int'(score), 255);
    chk("sat_hold_disp", int'(disp_code), 1);

    // async reset mid-hold
    cyc_n(2);
    rst_n = 0;
    #1;
    chk("arst_score", int'(score), 0);
    chk("arst_lives", int'(lives), 3);
    chk("arst_clr", int'(fsm_clr), 1);
    chk("arst_en", int'(fsm_en), 0);
    chk("arst_disp", int'(disp_code), 0);
    chk("arst_over", int'(game_over), 0);
    cyc_n(2);
    rst_n = 1;
    cyc_n(3);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
